// File: rtl/etapa_memoria_mem_wb_pkg.sv
// Shared definitions for the MEM stage: access-size encodings and the clogb2 width helper.
package etapa_memoria_mem_wb_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b11
  } mem_size_e;

  // Number of bits needed to represent 'depth' (clogb2(31) = 5, clogb2(1023) = 10).
  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned d;
    int unsigned r;
    d = depth;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (d > 0) begin
        r++;
        d = d >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/etapa_memoria_mem_wb_if.sv
// EX/MEM -> MEM/WB bundle: control/data from the previous stage and the latched write-back side.
interface etapa_memoria_mem_wb_if
  import etapa_memoria_mem_wb_pkg::*;
#(
  parameter int unsigned CANT_REGISTROS      = 32,
  parameter int unsigned CANT_BITS_REGISTROS = 32
) ();

  localparam int unsigned RW = clogb2(CANT_REGISTROS - 1);
  localparam int unsigned DW = CANT_BITS_REGISTROS;

  logic          i_enable;
  logic          i_flush;
  logic [RW-1:0] i_registro_destino;
  logic [DW-1:0] i_data_alu;
  logic [DW-1:0] i_data_store;
  logic          i_RegWrite;
  logic          i_MemtoReg;
  logic          i_MemRead;
  logic          i_MemWrite;
  logic [1:0]    i_mem_size;
  logic          i_unsigned;

  logic [RW-1:0] o_registro_destino;
  logic [DW-1:0] o_data_mem;
  logic [DW-1:0] o_data_alu;
  logic          o_RegWrite;
  logic          o_MemtoReg;
  logic          o_misaligned;
  logic          o_led;

  modport master (
    output i_enable, i_flush, i_registro_destino, i_data_alu, i_data_store,
           i_RegWrite, i_MemtoReg, i_MemRead, i_MemWrite, i_mem_size, i_unsigned,
    input  o_registro_destino, o_data_mem, o_data_alu, o_RegWrite, o_MemtoReg,
           o_misaligned, o_led
  );

  modport slave (
    input  i_enable, i_flush, i_registro_destino, i_data_alu, i_data_store,
           i_RegWrite, i_MemtoReg, i_MemRead, i_MemWrite, i_mem_size, i_unsigned,
    output o_registro_destino, o_data_mem, o_data_alu, o_RegWrite, o_MemtoReg,
           o_misaligned, o_led
  );

endinterface

// File: rtl/etapa_memoria_mem_wb_ram_datos.sv
// Data RAM: single-port, synchronous, read-first, 32-bit words with per-byte write enables.
module ram_datos #(
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read register is reset so the load path shows zero after reset; the array is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/etapa_memoria_mem_wb.sv
// MEM stage + MEM/WB latch: alignment check, byte-lane store, synchronous load with extension.
module etapa_memoria_mem_wb
  import etapa_memoria_mem_wb_pkg::*;
#(
  parameter int unsigned CANT_REGISTROS      = 32,
  parameter int unsigned CANT_BITS_REGISTROS = 32,
  parameter int unsigned RAM_DEPTH           = 1024
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  etapa_memoria_mem_wb_if.slave bus
);

  localparam int unsigned RW = clogb2(CANT_REGISTROS - 1);
  localparam int unsigned DW = CANT_BITS_REGISTROS;
  localparam int unsigned AW = clogb2(RAM_DEPTH - 1);

  logic [1:0]    off;
  logic          misaligned;
  logic          do_store;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   ram_rdata;

  logic [RW-1:0] dest_q;
  logic [DW-1:0] alu_q;
  logic          regwrite_q;
  logic          memtoreg_q;
  logic          misaligned_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          unsigned_q;

  logic [31:0]   shifted;
  logic [DW-1:0] data_mem;

  assign off = bus.i_data_alu[1:0];

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = bus.i_data_store[31:0];
    case (bus.i_mem_size)
      MEM_SIZE_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{bus.i_data_store[7:0]}};
      end
      MEM_SIZE_HALF: begin
        misaligned = off[0];
        be         = off[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{bus.i_data_store[15:0]}};
      end
      default: misaligned = (off != 2'b00);
    endcase
    misaligned = misaligned & (bus.i_MemRead | bus.i_MemWrite);
  end

  // Gated by i_reset as well so an edge during reset never writes the array.
  assign do_store = i_reset & bus.i_enable & ~bus.i_flush & bus.i_MemWrite & ~misaligned;

  ram_datos #(
    .RAM_DEPTH (RAM_DEPTH),
    .AW        (AW)
  ) u_ram_datos (
    .clk   (i_clock),
    .rst_n (i_reset),
    .en    (bus.i_enable),
    .we    (do_store ? be : 4'b0000),
    .addr  (bus.i_data_alu[AW+1:2]),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      dest_q       <= '0;
      alu_q        <= '0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      misaligned_q <= 1'b0;
      off_q        <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
    end else if (bus.i_enable) begin
      dest_q       <= bus.i_registro_destino;
      alu_q        <= bus.i_data_alu;
      regwrite_q   <= ~bus.i_flush & bus.i_RegWrite & ~misaligned;
      memtoreg_q   <= ~bus.i_flush & bus.i_MemtoReg;
      misaligned_q <= ~bus.i_flush & misaligned;
      off_q        <= off;
      size_q       <= bus.i_mem_size;
      unsigned_q   <= bus.i_unsigned;
    end
  end

  // Shifting the word down by the byte offset puts the addressed lane(s) at bit 0.
  assign shifted = ram_rdata >> {off_q, 3'b000};

  always_comb begin
    data_mem = DW'(shifted);
    case (size_q)
      MEM_SIZE_BYTE: data_mem = {{(DW-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
      MEM_SIZE_HALF: data_mem = {{(DW-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
      default:       data_mem = DW'(shifted);
    endcase
  end

  assign bus.o_registro_destino = dest_q;
  assign bus.o_data_alu         = alu_q;
  assign bus.o_data_mem         = data_mem;
  assign bus.o_RegWrite         = regwrite_q;
  assign bus.o_MemtoReg         = memtoreg_q;
  assign bus.o_misaligned       = misaligned_q;
  assign bus.o_led              = regwrite_q;

endmodule

// File: tb/tb_etapa_memoria_mem_wb.sv
// Bench for the MEM stage: directed load/store scenarios plus randomized traffic against a byte-array model.
module tb_etapa_memoria_mem_wb;
  import etapa_memoria_mem_wb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  etapa_memoria_mem_wb_if #(.CANT_REGISTROS(32), .CANT_BITS_REGISTROS(32)) bus ();

  etapa_memoria_mem_wb #(
    .CANT_REGISTROS      (32),
    .CANT_BITS_REGISTROS (32),
    .RAM_DEPTH           (1024)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] alu;
    logic        rw;
    logic        m2r;
    logic        mis;
    logic [31:0] dmem;
    bit          chk_fields;
    bit          chk_dmem;
  } exp_t;

  logic [7:0] mem_m [4096];
  exp_t e;
  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  task automatic model_reset();
    e.dest = '0; e.alu = '0; e.rw = 1'b0; e.m2r = 1'b0; e.mis = 1'b0; e.dmem = '0;
    e.chk_fields = 1'b1;
    e.chk_dmem   = 1'b1;
  endtask

  // Byte-addressed memory wrapping at 4 KiB; access of n bytes must sit on an n-byte boundary.
  task automatic model_edge();
    logic [31:0] a;
    logic [31:0] v;
    int unsigned n;
    bit mis;
    if (!rst_n || !bus.i_enable) return;
    a = bus.i_data_alu & 32'hFFF;
    n = (bus.i_mem_size == 2'b00) ? 1 : (bus.i_mem_size == 2'b01) ? 2 : 4;
    mis = (bus.i_MemRead || bus.i_MemWrite) && ((a % n) != 0);
    v = '0;
    for (int unsigned i = 0; i < n; i++) v |= 32'(mem_m[(a + i) & 32'hFFF]) << (8 * i);
    if (!bus.i_unsigned && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    if (bus.i_flush) begin
      e.rw = 1'b0; e.m2r = 1'b0; e.mis = 1'b0;
      e.chk_fields = 1'b0;
      e.chk_dmem   = 1'b0;
    end else begin
      e.dest = bus.i_registro_destino;
      e.alu  = bus.i_data_alu;
      e.rw   = bus.i_RegWrite && !mis;
      e.m2r  = bus.i_MemtoReg;
      e.mis  = mis;
      e.dmem = v;
      e.chk_fields = 1'b1;
      e.chk_dmem   = bus.i_MemRead && !mis;
      if (bus.i_MemWrite && !mis)
        for (int unsigned i = 0; i < n; i++)
          mem_m[(a + i) & 32'hFFF] = 8'(bus.i_data_store >> (8 * i));
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("o_RegWrite",   32'(bus.o_RegWrite),   32'(e.rw));
      chk("o_led",        32'(bus.o_led),        32'(e.rw));
      chk("o_MemtoReg",   32'(bus.o_MemtoReg),   32'(e.m2r));
      chk("o_misaligned", 32'(bus.o_misaligned), 32'(e.mis));
      if (e.chk_fields) begin
        chk("o_registro_destino", 32'(bus.o_registro_destino), 32'(e.dest));
        chk("o_data_alu",         bus.o_data_alu,              e.alu);
      end
      if (e.chk_dmem) chk("o_data_mem", bus.o_data_mem, e.dmem);
    end
  end

  task automatic drive(input bit en, input bit fl, input logic [31:0] addr, input logic [31:0] st,
                       input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input bit rw, input logic [4:0] dest);
    bus.i_enable           = en;
    bus.i_flush            = fl;
    bus.i_data_alu         = addr;
    bus.i_data_store       = st;
    bus.i_MemRead          = rd;
    bus.i_MemWrite         = wr;
    bus.i_mem_size         = sz;
    bus.i_unsigned         = uns;
    bus.i_RegWrite         = rw;
    bus.i_MemtoReg         = rd;
    bus.i_registro_destino = dest;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] sz);
    drive(1, 0, addr, d, 0, 1, sz, 0, 0, 5'($urandom));
    cycle();
  endtask

  task automatic ld(input logic [31:0] addr, input logic [1:0] sz, input bit uns);
    drive(1, 0, addr, $urandom, 1, 0, sz, uns, 1, 5'($urandom));
    cycle();
  endtask

  int unsigned kind;
  logic [31:0] raddr;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 cmp_on = 1'b1;
    chk("reset_regwrite", 32'(bus.o_RegWrite), 32'h0);
    chk("reset_data_mem", bus.o_data_mem, 32'h0);
    repeat (2) cycle();
    @(negedge clk) rst_n = 1'b1;

    for (int unsigned w = 0; w < 16; w++) st(4 * w, $urandom, 2'b11);

    st(32'h8, 32'h1234_5678, 2'b11);
    ld(32'h8, 2'b11, 0); chk("lw_8",  bus.o_data_mem, 32'h1234_5678);
    ld(32'h8, 2'b00, 0); chk("lb_8",  bus.o_data_mem, 32'h0000_0078);
    ld(32'hB, 2'b00, 0); chk("lb_B",  bus.o_data_mem, 32'h0000_0012);
    st(32'h9, 32'h0000_0080, 2'b00);
    ld(32'h9, 2'b00, 0); chk("lb_9",  bus.o_data_mem, 32'hFFFF_FF80);
    ld(32'h9, 2'b00, 1); chk("lbu_9", bus.o_data_mem, 32'h0000_0080);
    ld(32'h8, 2'b11, 0); chk("lw_8b", bus.o_data_mem, 32'h1234_8078);

    drive(1, 0, 32'h9, 32'h0000_BEEF, 0, 1, 2'b01, 0, 1, 5'd7);
    cycle();
    chk("sh_mis_flag", 32'(bus.o_misaligned), 32'h1);
    chk("sh_mis_rw",   32'(bus.o_RegWrite),   32'h0);
    ld(32'h8, 2'b11, 0); chk("lw_after_mis", bus.o_data_mem, 32'h1234_8078);

    drive(0, 0, 32'h8, 32'hCAFE_F00D, 0, 1, 2'b11, 0, 1, 5'd9);
    repeat (3) begin
      cycle();
      chk("freeze_data_mem", bus.o_data_mem, 32'h1234_8078);
      chk("freeze_regwrite", 32'(bus.o_RegWrite), 32'h1);
    end
    bus.i_enable = 1'b1;
    cycle();
    ld(32'h8, 2'b11, 0); chk("lw_after_freeze", bus.o_data_mem, 32'hCAFE_F00D);

    st(32'h0, 32'h0BAD_F00D, 2'b11);
    drive(1, 1, 32'h0, 32'hDEAD_BEEF, 0, 1, 2'b11, 0, 1, 5'd4);
    cycle();
    chk("flush_regwrite", 32'(bus.o_RegWrite), 32'h0);
    ld(32'h0, 2'b11, 0); chk("lw_after_flush", bus.o_data_mem, 32'h0BAD_F00D);

    st(32'h4, 32'h0102_0304, 2'b11);
    ld(32'h4, 2'b11, 0);
    drive(1, 0, 32'h4, 32'h55AA_55AA, 0, 1, 2'b11, 0, 1, 5'd3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_data_mem", bus.o_data_mem, 32'h0);
    chk("rst_mid_alu",      bus.o_data_alu, 32'h0);
    chk("rst_mid_dest",     32'(bus.o_registro_destino), 32'h0);
    chk("rst_mid_regwrite", 32'(bus.o_RegWrite), 32'h0);
    repeat (2) cycle();
    @(negedge clk) rst_n = 1'b1;
    ld(32'h4, 2'b11, 0); chk("lw_after_reset", bus.o_data_mem, 32'h0102_0304);

    st(32'h1000, 32'hA5A5_A5A5, 2'b11);
    ld(32'h0, 2'b11, 0); chk("lw_wrap", bus.o_data_mem, 32'hA5A5_A5A5);

    for (int unsigned k = 0; k < 400; k++) begin
      kind  = $urandom_range(0, 2);
      raddr = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), raddr, $urandom,
            (kind == 0), (kind == 1), 2'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      cycle();
    end

    drive(1, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
    repeat (2) cycle();
    @(negedge clk);
    #1 cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
